// File: rtl/mult_div_ex_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit.
// Holds the op encodings and the busy-counter width.
package mult_div_ex_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CNT_W = 16;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_ex_if.sv
// EX-stage request bundle and HI/LO/busy return path.
// master drives requests, slave is the multiply/divide unit.
interface mult_div_ex_if;
    import mult_div_ex_pkg::*;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, hi, lo
    );

endinterface

// File: rtl/mult_div_ex.sv
// Multi-cycle MULT/DIV unit owning HI/LO; result is formed from the
// latched operands and committed on the edge that ends the busy period.
module mult_div_ex
    import mult_div_ex_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_ex_if.slave  ex
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]        mul_s;
    logic [63:0]        mul_u;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        ub;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign mul_s = $signed({{32{a_q[31]}}, a_q})
                 * $signed({{32{b_q[31]}}, b_q});
    assign mul_u = {32'd0, a_q} * {32'd0, b_q};

    // Divisor is forced to 1 in the zero/overflow cases so the
    // dividers never see an undefined operand pair.
    assign div_zero = (b_q == 32'd0);
    assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign sa       = $signed(a_q);
    assign sb       = (div_zero || div_ovf) ? 32'sd1 : $signed(b_q);
    assign ub       = div_zero ? 32'd1 : b_q;
    assign quot_s   = sa / sb;
    assign rem_s    = sa % sb;
    assign quot_u   = a_q / ub;
    assign rem_u    = a_q % ub;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (ex.start) begin
                    unique case (1'b1)
                        is_mul(ex.op): begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            op_d    = ex.op;
                            a_d     = ex.rs_data;
                            b_d     = ex.rt_data;
                        end
                        is_div(ex.op): begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = ex.op;
                            a_d     = ex.rs_data;
                            b_d     = ex.rt_data;
                        end
                        (ex.op == OP_MTHI): hi_d = ex.rs_data;
                        (ex.op == OP_MTLO): lo_d = ex.rs_data;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = mul_s;
                        OP_MULTU: {hi_d, lo_d} = mul_u;
                        OP_DIV: begin
                            if (div_ovf) begin
                                lo_d = 32'h8000_0000;
                                hi_d = 32'd0;
                            end else if (!div_zero) begin
                                lo_d = quot_s;
                                hi_d = rem_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                lo_d = quot_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ex.busy = (state_q == RUN);
    assign ex.hi   = hi_q;
    assign ex.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_ex.sv
// Directed bench for mult_div_ex: hand-computed HI/LO results,
// busy-period lengths, ignored requests, reset abort and back-to-back issue.
module tb_mult_div_ex;
    import mult_div_ex_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   n;

    mult_div_ex_if bus ();

    mult_div_ex #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single cycle; operands are scrambled
    // right after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.rs_data = 32'hDEAD_BEEF;
        bus.rt_data = 32'h0BAD_F00D;
    endtask

    task automatic wait_idle(input int limit, inout int cnt);
        while (bus.busy === 1'b1 && cnt < limit) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_busy", {31'd0, bus.busy}, 32'd1);
        chk("mult_hold_hi", bus.hi, 32'd0);
        n = 0;
        wait_idle(40, n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFE);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        n = 0;
        wait_idle(40, n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", bus.hi, 32'h0000_0001);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        n = 0;
        wait_idle(40, n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'd7, 32'd2);
        n = 0;
        wait_idle(40, n);
        chk("divu_cycles", n, 32'd10);
        chk("divu_lo", bus.lo, 32'd3);
        chk("divu_hi", bus.hi, 32'd1);

        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_lo", bus.lo, 32'd3);

        issue(OP_DIVU, 32'd99, 32'd0);
        n = 0;
        wait_idle(40, n);
        chk("dz_cycles", n, 32'd10);
        chk("dz_hi", bus.hi, 32'h1234_5678);
        chk("dz_lo", bus.lo, 32'd3);

        // MULT -3 x 5 with MTLO and DIV attempted while busy
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        n = 0;
        issue(OP_MTLO, 32'h0000_AAAA, 32'd0);
        n++;
        chk("ign_mtlo_lo", bus.lo, 32'd3);
        issue(OP_DIV, 32'd100, 32'd3);
        n++;
        chk("ign_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle(40, n);
        chk("ign_cycles", n, 32'd5);
        chk("ign_hi", bus.hi, 32'hFFFF_FFFF);
        chk("ign_lo", bus.lo, 32'hFFFF_FFF1);
        @(posedge clk);
        #1;
        chk("ign_no_div", {31'd0, bus.busy}, 32'd0);

        // Reset in busy cycle 3 of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(OP_MULTU, 32'd3, 32'd4);
        n = 0;
        wait_idle(40, n);
        chk("post_rst_cycles", n, 32'd5);
        chk("post_rst_lo", bus.lo, 32'd12);
        chk("post_rst_hi", bus.hi, 32'd0);

        issue(3'd6, 32'h5555_5555, 32'd1);
        chk("unused_busy", {31'd0, bus.busy}, 32'd0);
        chk("unused_hi", bus.hi, 32'd0);
        chk("unused_lo", bus.lo, 32'd12);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n = 0;
        wait_idle(40, n);
        chk("ovf_cycles", n, 32'd10);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);
        issue(OP_MULTU, 32'd2, 32'd3);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        n = 0;
        wait_idle(40, n);
        chk("b2b_cycles", n, 32'd5);
        chk("b2b_lo", bus.lo, 32'd6);
        chk("b2b_hi", bus.hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
